// File: rtl/gate_eval_arbiter.sv
// gate_eval_arbiter
//
// Round-robin arbiter in front of a single shared bitwise gate evaluator.
// One request is accepted from IDLE, evaluated in EVAL and presented in RESP
// until the consumer takes it, giving a minimum of three cycles per transaction.
//
// Parameters:
//   NREQ - number of requesters (2..8)
//   W    - operand/result width
//
// Ports:
//   clk        - clock, rising edge
//   rst_n      - synchronous active-low reset
//   req_valid  - per-requester request valid
//   req_ready  - per-requester accept strobe (one-hot or zero, IDLE only)
//   req_op     - per-requester opcode, requester i at [3i+2:3i]
//   req_a      - per-requester operand A, requester i at [Wi+W-1:Wi]
//   req_b      - per-requester operand B, requester i at [Wi+W-1:Wi]
//   rsp_valid  - result valid (RESP only)
//   rsp_ready  - result consumer ready
//   rsp_id     - index of the served requester
//   rsp_data   - gate result
//   busy       - high whenever not in IDLE
//   grant_cnt  - per-requester saturating accept counters, 8 bits each
//                (present only when GATE_EVAL_ARBITER_STATS_EN is defined)
//
// Opcodes: 0 BUF A, 1 NOT A, 2 AND, 3 NAND, 4 OR, 5 NOR, 6 XOR, 7 XNOR.

module gate_eval_arbiter #(
   parameter int NREQ = 4,
   parameter int W    = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NREQ-1:0]          req_valid,
   output logic [NREQ-1:0]          req_ready,
   input  logic [3*NREQ-1:0]        req_op,
   input  logic [W*NREQ-1:0]        req_a,
   input  logic [W*NREQ-1:0]        req_b,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [$clog2(NREQ)-1:0]  rsp_id,
   output logic [W-1:0]             rsp_data,
   output logic                     busy
`ifdef GATE_EVAL_ARBITER_STATS_EN
   ,
   output logic [8*NREQ-1:0]        grant_cnt
`endif
);

   localparam int IDW = $clog2(NREQ);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EVAL = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0]     state_q, state_d;
   logic [IDW-1:0] rr_ptr_q;
   logic [IDW-1:0] win_idx;
   logic           win_found;
   logic           accept;
   logic [2:0]     op_q;
   logic [W-1:0]   a_q, b_q;
   logic [W-1:0]   eval_res;

   // Round-robin search starting at rr_ptr_q, wrapping at NREQ (not a power of two
   // in general, so the wrap is an explicit subtract rather than a truncation).
   always_comb begin
      int idx;
      win_found = 1'b0;
      win_idx   = '0;
      idx       = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!win_found && req_valid[idx]) begin
            win_found = 1'b1;
            win_idx   = IDW'(idx);
         end
      end
   end

   // Gated by rst_n so no strobe escapes while reset is asserted.
   assign accept = rst_n && (state_q == IDLE) && win_found;

   always_comb begin
      req_ready = '0;
      if (accept) req_ready[win_idx] = 1'b1;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = EVAL;
         EVAL:    state_d = RESP;
         RESP:    if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Plain four-state operators so x/z operand bits propagate naturally.
   always_comb begin
      eval_res = a_q;
      case (op_q)
         3'd0: eval_res = a_q;
         3'd1: eval_res = ~a_q;
         3'd2: eval_res = a_q & b_q;
         3'd3: eval_res = ~(a_q & b_q);
         3'd4: eval_res = a_q | b_q;
         3'd5: eval_res = ~(a_q | b_q);
         3'd6: eval_res = a_q ^ b_q;
         3'd7: eval_res = ~(a_q ^ b_q);
         default: eval_res = a_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         rsp_id   <= '0;
         rsp_data <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op_q     <= req_op[3*win_idx +: 3];
            a_q      <= req_a[W*win_idx +: W];
            b_q      <= req_b[W*win_idx +: W];
            rsp_id   <= win_idx;
            rr_ptr_q <= (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
         end
         if (state_q == EVAL) rsp_data <= eval_res;
      end
   end

   assign rsp_valid = (state_q == RESP);
   assign busy      = (state_q != IDLE);

`ifdef GATE_EVAL_ARBITER_STATS_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         grant_cnt <= '0;
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (accept && (win_idx == IDW'(i)) && (grant_cnt[8*i +: 8] != 8'hFF)) begin
               grant_cnt[8*i +: 8] <= grant_cnt[8*i +: 8] + 8'd1;
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_gate_eval_arbiter.sv
// Bench for gate_eval_arbiter (default build, NREQ=4, W=8).
// Directed steps followed by randomized transactions, each checked against a
// transaction-level model: round-robin pick over the offered valids and a
// per-bit truth table for the gate function.

module tb_gate_eval_arbiter;

   localparam int NREQ = 4;
   localparam int W    = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [11:0] req_op;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [1:0]  rsp_id;
   logic [7:0]  rsp_data;
   logic        busy;

   int total = 0;
   int bad   = 0;
   int ptr   = 0;   // model round-robin pointer

   // Truth table per opcode indexed by {a,b}.
   bit [3:0]   tt [8] = '{4'b1100, 4'b0011, 4'b1000, 4'b0111,
                          4'b1110, 4'b0001, 4'b0110, 4'b1001};
   logic [7:0] sweep_exp [8] = '{8'hA5, 8'h5A, 8'h05, 8'hFA, 8'hAF, 8'h50, 8'hAA, 8'h55};
   int         order_exp [5] = '{0, 1, 2, 3, 0};

   gate_eval_arbiter #(.NREQ(NREQ), .W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int pick(input logic [3:0] v, input int p);
      for (int k = 0; k < NREQ; k++) begin
         if (v[(p + k) % NREQ] === 1'b1) return (p + k) % NREQ;
      end
      return -1;
   endfunction

   function automatic logic [7:0] gate_ref(input logic [2:0] op, input logic [7:0] a,
                                           input logic [7:0] b);
      logic [7:0] r;
      bit [3:0]   t;
      t = tt[op];
      for (int i = 0; i < 8; i++) r[i] = t[{a[i], b[i]}];
      return r;
   endfunction

   // Called at posedge+1 with the DUT in IDLE; returns at posedge+1 back in IDLE.
   task automatic run_txn(input logic [3:0] v, input logic [11:0] ops, input logic [31:0] as,
                          input logic [31:0] bs, input int stall, input bit use_fexp,
                          input logic [7:0] fexp, output logic [7:0] got, output int gid);
      int         w;
      logic [7:0] exp_d;
      logic [3:0] exp_rdy;
      req_valid = v;
      req_op    = ops;
      req_a     = as;
      req_b     = bs;
      rsp_ready = (stall == 0);
      #1;
      w       = pick(v, ptr);
      gid     = w;
      got     = '0;
      exp_rdy = '0;
      if (w >= 0) exp_rdy[w] = 1'b1;
      chk("req_ready_idle", 32'(req_ready), 32'(exp_rdy));
      chk("busy_idle", 32'(busy), 32'd0);
      chk("rsp_valid_idle", 32'(rsp_valid), 32'd0);
      if (w < 0) begin
         tick();
         return;
      end
      exp_d = use_fexp ? fexp : gate_ref(ops[3*w +: 3], as[8*w +: 8], bs[8*w +: 8]);
      ptr   = (w + 1) % NREQ;
      tick();
      // EVAL: scramble inputs; the result must come from the captured values.
      req_valid = 4'($urandom);
      req_op    = 12'($urandom);
      req_a     = $urandom;
      req_b     = $urandom;
      #1;
      chk("req_ready_eval", 32'(req_ready), 32'd0);
      chk("rsp_valid_eval", 32'(rsp_valid), 32'd0);
      chk("busy_eval", 32'(busy), 32'd1);
      tick();
      chk("rsp_valid_resp", 32'(rsp_valid), 32'd1);
      chk("rsp_id_resp", 32'(rsp_id), 32'(w));
      chk("rsp_data_resp", 32'(rsp_data), 32'(exp_d));
      chk("req_ready_resp", 32'(req_ready), 32'd0);
      got = rsp_data;
      for (int s = 0; s < stall; s++) begin
         req_a     = $urandom;
         req_valid = 4'($urandom);
         tick();
         chk("rsp_valid_stall", 32'(rsp_valid), 32'd1);
         chk("rsp_id_stall", 32'(rsp_id), 32'(w));
         chk("rsp_data_stall", 32'(rsp_data), 32'(exp_d));
         chk("req_ready_stall", 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      tick();
      chk("busy_after", 32'(busy), 32'd0);
   endtask

   initial begin
      logic [7:0] got;
      int         gid;
      int         w;
      logic [3:0] exp_rdy;

      // Reset with all requests pending: no strobes, everything cleared.
      rst_n     = 1'b0;
      req_valid = 4'hF;
      req_op    = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b1;
      tick();
      tick();
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_id", 32'(rsp_id), 32'd0);
      chk("rst_rsp_data", 32'(rsp_data), 32'd0);
      rst_n     = 1'b1;
      req_valid = '0;

      // Single AND request from requester 0.
      run_txn(4'b0001, 12'h002, 32'h0000_00F0, 32'h0000_003C, 0, 1'b0, 8'h00, got, gid);
      chk("basic_and_data", 32'(got), 32'h30);
      chk("basic_and_id", 32'(gid), 32'd0);

      // Reset during EVAL abandons the transaction and clears the pointer.
      req_valid = 4'b0100;
      req_op    = 12'h600;
      req_a     = 32'h5A00_0000;
      req_b     = 32'h00FF_0000;
      rsp_ready = 1'b1;
      #1;
      w       = pick(4'b0100, ptr);
      exp_rdy = '0;
      exp_rdy[w] = 1'b1;
      chk("rstmid_grant", 32'(req_ready), 32'(exp_rdy));
      tick();
      rst_n     = 1'b0;
      req_valid = '0;
      #1;
      chk("rstmid_ready_low", 32'(req_ready), 32'd0);
      tick();
      rst_n = 1'b1;
      ptr   = 0;
      chk("rstmid_busy", 32'(busy), 32'd0);
      chk("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rstmid_rsp_id", 32'(rsp_id), 32'd0);
      chk("rstmid_rsp_data", 32'(rsp_data), 32'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("rstmid_no_stale", 32'(rsp_valid), 32'd0);
      end

      // All four requesting continuously: strict rotation from 0.
      for (int k = 0; k < 5; k++) begin
         run_txn(4'hF, 12'($urandom), $urandom, $urandom, 0, 1'b0, 8'h00, got, gid);
         chk("rr_order", 32'(gid), 32'(order_exp[k]));
      end

      // Opcode sweep, same operands offered by everyone.
      for (int op = 0; op < 8; op++) begin
         run_txn(4'hF, {4{3'(op)}}, {4{8'hA5}}, {4{8'h0F}}, 0, 1'b0, 8'h00, got, gid);
         chk("sweep_data", 32'(got), 32'(sweep_exp[op]));
      end

      // Unknown operand bits propagate through OR and are masked by AND with 0.
      w = ptr;
      run_txn(4'(1 << w), {4{3'd4}}, {4{8'bxxxx_0101}}, {4{8'h0F}}, 0, 1'b1, 8'bxxxx_1111,
              got, gid);
      w = ptr;
      run_txn(4'(1 << w), {4{3'd2}}, {4{8'bxxxx_0101}}, {4{8'h0F}}, 0, 1'b1, 8'b0000_0101,
              got, gid);

      // Consumer stalls for five cycles in RESP.
      run_txn(4'b1000, 12'h700, 32'h3C00_0000, 32'h0F00_0000, 5, 1'b0, 8'h00, got, gid);

      // Randomized transactions, including empty cycles and partial valid sets.
      for (int k = 0; k < 40; k++) begin
         run_txn(4'($urandom_range(0, 15)), 12'($urandom), $urandom, $urandom,
                 int'($urandom_range(0, 3)), 1'b0, 8'h00, got, gid);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/gate_eval_arbiter.md
GATE_EVAL_ARBITER -- requirements
Module: gate_eval_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters, legal 2..8.
REQ-002 SHALL have parameter W, default 8: operand/result width in bits.
REQ-003 SHALL have port clk, input, 1: single clock, rising-edge active.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port req_valid, input, NREQ: per-requester request valid.
REQ-006 SHALL have port req_ready, output, NREQ: per-requester accept strobe, at most one bit set.
REQ-007 SHALL have port req_op, input, 3*NREQ: per-requester gate opcode, requester i at [3i+2:3i].
REQ-008 SHALL have port req_a, input, W*NREQ: per-requester operand A.
REQ-009 SHALL have port req_b, input, W*NREQ: per-requester operand B.
REQ-010 SHALL have port rsp_valid, output, 1: result valid.
REQ-011 SHALL have port rsp_ready, input, 1: result consumer ready.
REQ-012 SHALL have port rsp_id, output, $clog2(NREQ): index of the served requester.
REQ-013 SHALL have port rsp_data, output, W: gate result.
REQ-014 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-015 SHALL implement FSM IDLE -> EVAL -> RESP -> IDLE, one shared evaluation unit.
REQ-016 In IDLE, with any req_valid high, SHALL select the winner round-robin, searching upward from rr_ptr with wrap.
REQ-017 SHALL drive req_ready combinationally, one-hot for the winner, only in IDLE; all zero elsewhere.
REQ-018 On handshake, SHALL capture op/A/B/id, set rr_ptr = (winner+1) mod NREQ, and go to EVAL.
REQ-019 In EVAL, SHALL register rsp_data per opcode, bitwise: 0 BUF A, 1 NOT A, 2 AND, 3 NAND, 4 OR, 5 NOR, 6 XOR, 7 XNOR; then go to RESP.
REQ-020 x/z operand bits SHALL propagate per standard four-state bitwise operator semantics; no masking.
REQ-021 In RESP, SHALL hold rsp_valid=1 with rsp_id/rsp_data stable until rsp_ready=1; that cycle returns to IDLE.
REQ-022 Latency: accept in cycle N, rsp_valid first high in cycle N+2; minimum 3 cycles per transaction.
REQ-023 A requester deasserting req_valid before being granted SHALL lose no state and needs no handshake.
REQ-024 Requests arriving in EVAL/RESP SHALL wait; no request is dropped while it stays valid.
REQ-025 With NREQ not a power of two, rr_ptr SHALL wrap at NREQ-1 -> 0 and never hold an illegal index.
REQ-026 rsp_valid SHALL be low in IDLE and EVAL.

Reset
REQ-027 rst_n=0 at a clock edge SHALL force IDLE, rr_ptr=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0.
REQ-028 Reset mid-transaction SHALL abandon it; no response is produced for it after release.
REQ-029 While rst_n=0, req_ready SHALL be all zero.

Configuration
REQ-030 With macro GATE_EVAL_ARBITER_STATS_EN defined, SHALL add output grant_cnt, 8*NREQ bits: per-requester saturating (stops at 255) count of accepted requests, cleared by reset.
REQ-031 Without GATE_EVAL_ARBITER_STATS_EN, grant_cnt SHALL be absent; all other behaviour identical.

Verification
REQ-032 Reset, then req_valid=0001, op=2, A=8'hF0, B=8'h3C, rsp_ready=1 -> req_ready=0001 at N, rsp_valid at N+2 with rsp_data=8'h30, rsp_id=0.
REQ-033 All four valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0; each requester served once per 12 cycles.
REQ-034 Opcode sweep 0..7 with A=8'hA5, B=8'h0F -> A5,5A,05,FA,AF,50,AA,55.
REQ-035 rsp_ready held 0 for 5 cycles in RESP -> rsp_valid, rsp_id, rsp_data stable; req_ready=0 throughout.
REQ-036 rst_n pulsed low during EVAL -> next cycle IDLE, rsp_valid=0, rr_ptr=0; no stale response afterwards.
REQ-037 With GATE_EVAL_ARBITER_STATS_EN, 300 grants to requester 2 -> grant_cnt[23:16]=255, other fields unchanged.
